// File: rtl/pc_branch_unit.sv
// Fetch PC register with bimodal branch prediction at ID and beq/bne resolution at EX.
// Drives redirect/flush controls and keeps saturating branch/mispredict counters.
module pc_branch_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BHT_DEPTH = 16,
    parameter int                IDX_LSB   = 2,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] id_target,
    output logic              id_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_bne,
    input  logic              ex_eq,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    output logic              mispredict,
    output logic              flush_if,
    output logic              flush_id,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]        r_bht [BHT_DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_branchCnt;
    logic [CNT_W-1:0]  r_mispredictCnt;

    logic [IDX_W-1:0]  w_idIdx;
    logic [IDX_W-1:0]  w_exIdx;
    logic              w_exResolved;
    logic              w_exActual;
    logic              w_mispredict;
    logic              w_idPredTaken;
    logic              w_idRedirect;
    logic [ADDR_W-1:0] w_nextPc;
    logic              w_unusedIdPc;

    assign w_idIdx       = id_pc[IDX_LSB +: IDX_W];
    assign w_exIdx       = ex_pc[IDX_LSB +: IDX_W];
    assign w_unusedIdPc  = ^id_pc;
    assign w_exResolved  = ex_valid & ex_branch;
    assign w_exActual    = w_exResolved & (ex_bne ? ~ex_eq : ex_eq);
    assign w_mispredict  = w_exResolved & (w_exActual != ex_pred_taken);
    assign w_idPredTaken = id_valid & id_branch & r_bht[w_idIdx][1];
    assign w_idRedirect  = ~stall & id_valid & (id_jump | w_idPredTaken);

    // An EX mispredict outranks everything, including stall.
    always_comb begin
        w_nextPc = r_pc + ADDR_W'(4);
        if (w_mispredict) begin
            w_nextPc = w_exActual ? ex_target : ex_pc + ADDR_W'(4);
        end else if (w_idRedirect) begin
            w_nextPc = id_target;
        end else if (stall) begin
            w_nextPc = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    // ID reads the table combinationally, so a same-index update lands only next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_exResolved) begin
            if (w_exActual) begin
                if (r_bht[w_exIdx] != 2'b11) begin
                    r_bht[w_exIdx] <= r_bht[w_exIdx] + 2'd1;
                end
            end else if (r_bht[w_exIdx] != 2'b00) begin
                r_bht[w_exIdx] <= r_bht[w_exIdx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branchCnt     <= '0;
            r_mispredictCnt <= '0;
        end else begin
            if (w_exResolved && (r_branchCnt != '1)) begin
                r_branchCnt <= r_branchCnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispredictCnt != '1)) begin
                r_mispredictCnt <= r_mispredictCnt + CNT_W'(1);
            end
        end
    end

    assign pc             = r_pc;
    assign id_pred_taken  = w_idPredTaken;
    assign mispredict     = w_mispredict;
    assign flush_if       = w_mispredict | w_idRedirect;
    assign flush_id       = w_mispredict;
    assign branch_cnt     = r_branchCnt;
    assign mispredict_cnt = r_mispredictCnt;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed plus randomized bench for pc_branch_unit against a behavioural next-PC/BHT model.
// A second instance with 2-bit performance counters shares all inputs to exercise saturation.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, idValid, idBranch, idJump;
    logic [31:0] idPc, idTarget;
    logic        exValid, exBranch, exBne, exEq, exPredTaken;
    logic [31:0] exPc, exTarget;

    logic [31:0] pc, pc2;
    logic        idPred, idPred2, mis, mis2, flushIf, flushIf2, flushId, flushId2;
    logic [15:0] brCnt, misCnt;
    logic [1:0]  brCnt2, misCnt2;

    int compared = 0;
    int mismatched = 0;

    int          mBht [16];
    logic [31:0] mPc;
    int          mBr, mMis, mBr2, mMis2;

    always #5 clk = ~clk;

    pc_branch_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc),
        .id_valid(idValid), .id_branch(idBranch), .id_jump(idJump),
        .id_pc(idPc), .id_target(idTarget), .id_pred_taken(idPred),
        .ex_valid(exValid), .ex_branch(exBranch), .ex_bne(exBne), .ex_eq(exEq),
        .ex_pc(exPc), .ex_target(exTarget), .ex_pred_taken(exPredTaken),
        .mispredict(mis), .flush_if(flushIf), .flush_id(flushId),
        .branch_cnt(brCnt), .mispredict_cnt(misCnt)
    );

    pc_branch_unit #(.CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc2),
        .id_valid(idValid), .id_branch(idBranch), .id_jump(idJump),
        .id_pc(idPc), .id_target(idTarget), .id_pred_taken(idPred2),
        .ex_valid(exValid), .ex_branch(exBranch), .ex_bne(exBne), .ex_eq(exEq),
        .ex_pc(exPc), .ex_target(exTarget), .ex_pred_taken(exPredTaken),
        .mispredict(mis2), .flush_if(flushIf2), .flush_id(flushId2),
        .branch_cnt(brCnt2), .mispredict_cnt(misCnt2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit iv, input bit ib, input bit ij,
                                 input logic [31:0] ip, input logic [31:0] it,
                                 input bit ev, input bit eb, input bit ebne, input bit eeq,
                                 input logic [31:0] ep, input logic [31:0] et, input bit epred);
        stall = st; idValid = iv; idBranch = ib; idJump = ij; idPc = ip; idTarget = it;
        exValid = ev; exBranch = eb; exBne = ebne; exEq = eeq; exPc = ep; exTarget = et;
        exPredTaken = epred;
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mBht[i] = 1;
        mPc = 32'h0; mBr = 0; mMis = 0; mBr2 = 0; mMis2 = 0;
    endtask

    function automatic int tableIndex(input logic [31:0] addr);
        return int'((addr / 4) % 16);
    endfunction

    // One clock: check the combinational outputs, take the edge, advance the model, check state.
    task automatic runCycle();
        bit          pred, actual, wrong, redirect;
        logic [31:0] nextPc;
        int          exIdx;
        pred     = idValid && idBranch && (mBht[tableIndex(idPc)] >= 2);
        actual   = exValid && exBranch && (exBne ? !exEq : exEq);
        wrong    = exValid && exBranch && (actual != exPredTaken);
        redirect = !stall && idValid && (idJump || pred);
        if (wrong)         nextPc = actual ? exTarget : exPc + 32'd4;
        else if (redirect) nextPc = idTarget;
        else if (stall)    nextPc = mPc;
        else               nextPc = mPc + 32'd4;
        #1;
        checkOutput("idPredTaken", {31'b0, idPred}, {31'b0, pred});
        checkOutput("mispredict", {31'b0, mis}, {31'b0, wrong});
        checkOutput("flushIf", {31'b0, flushIf}, {31'b0, wrong || redirect});
        checkOutput("flushId", {31'b0, flushId}, {31'b0, wrong});
        @(posedge clk);
        if (exValid && exBranch) begin
            exIdx = tableIndex(exPc);
            if (actual && mBht[exIdx] < 3) mBht[exIdx]++;
            if (!actual && mBht[exIdx] > 0) mBht[exIdx]--;
            if (mBr < 65535) mBr++;
            if (mBr2 < 3) mBr2++;
        end
        if (wrong) begin
            if (mMis < 65535) mMis++;
            if (mMis2 < 3) mMis2++;
        end
        mPc = nextPc;
        #1;
        checkOutput("pc", pc, mPc);
        checkOutput("pcSat", pc2, mPc);
        checkOutput("branchCnt", {16'b0, brCnt}, mBr);
        checkOutput("mispredictCnt", {16'b0, misCnt}, mMis);
        checkOutput("branchCntSat", {30'b0, brCnt2}, mBr2);
        checkOutput("mispredictCntSat", {30'b0, misCnt2}, mMis2);
    endtask

    initial begin
        applyIdle();
        modelReset();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("resetPc", pc, 32'h0);
        checkOutput("resetBranchCnt", {16'b0, brCnt}, 32'h0);
        checkOutput("resetMispredictCnt", {16'b0, misCnt}, 32'h0);
        checkOutput("resetFlushIf", {31'b0, flushIf}, 32'h0);
        checkOutput("resetMispredict", {31'b0, mis}, 32'h0);
        #1 rst_n = 1'b1;

        runCycle();
        runCycle();
        checkOutput("seqPc8", pc, 32'h8);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        runCycle();
        checkOutput("stallHold", pc, 32'h8);
        applyIdle();
        runCycle();
        checkOutput("afterStall", pc, 32'hC);

        applyStimulus(0, 1, 0, 1, 32'h20, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        runCycle();
        checkOutput("jumpTop", pc, 32'hFFFF_FFFC);
        applyIdle();
        runCycle();
        checkOutput("wrapZero", pc, 32'h0);

        applyStimulus(0, 1, 1, 0, 32'h10, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("coldPred", {31'b0, idPred}, 32'h0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h10, 32'h40, 0);
        #1 checkOutput("coldFlushId", {31'b0, flushId}, 32'h1);
        runCycle();
        checkOutput("coldPc", pc, 32'h40);
        checkOutput("coldBranchCnt", {16'b0, brCnt}, 32'h1);
        checkOutput("coldMisCnt", {16'b0, misCnt}, 32'h1);

        applyStimulus(0, 1, 1, 0, 32'h10, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("warmPred", {31'b0, idPred}, 32'h1);
        runCycle();
        checkOutput("warmPc", pc, 32'h40);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h10, 32'h40, 1);
        runCycle();

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h10, 32'h40, 1);
        #1 checkOutput("bneMis", {31'b0, mis}, 32'h1);
        runCycle();
        checkOutput("bnePc", pc, 32'h14);
        applyStimulus(1, 1, 1, 0, 32'h10, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("stallPred", {31'b0, idPred}, 32'h1);
        checkOutput("stallNoFlush", {31'b0, flushIf}, 32'h0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h10, 32'h40, 1);
        runCycle();
        applyStimulus(0, 1, 1, 0, 32'h10, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("decayPred", {31'b0, idPred}, 32'h0);
        runCycle();

        applyStimulus(1, 1, 0, 1, 32'h60, 32'h200, 1, 1, 0, 1, 32'h30, 32'h80, 0);
        #1 checkOutput("prioFlushIf", {31'b0, flushIf}, 32'h1);
        checkOutput("prioFlushId", {31'b0, flushId}, 32'h1);
        runCycle();
        checkOutput("prioPc", pc, 32'h80);
        applyStimulus(1, 1, 0, 1, 32'h60, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("stallJumpFlush", {31'b0, flushIf}, 32'h0);
        runCycle();
        checkOutput("stallJumpPc", pc, 32'h80);

        applyIdle();
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncPc", pc, 32'h0);
        checkOutput("asyncBranchCnt", {16'b0, brCnt}, 32'h0);
        checkOutput("asyncMisCntSat", {30'b0, misCnt2}, 32'h0);
        rst_n = 1'b1;
        applyStimulus(0, 1, 1, 0, 32'h30, 32'h90, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("asyncBhtCleared", {31'b0, idPred}, 32'h0);
        runCycle();
        checkOutput("firstAfterReset", pc, 32'h4);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h100, 32'h300, 1);
        for (int i = 0; i < 5; i++) runCycle();
        checkOutput("satMisCnt", {30'b0, misCnt2}, 32'h3);
        checkOutput("fullMisCnt", {16'b0, misCnt}, 32'h5);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ip, ep;
            int          kind;
            bit          ev, epred;
            ip   = 32'(4 * $urandom_range(0, 31));
            ep   = 32'(4 * $urandom_range(0, 31));
            kind = $urandom_range(0, 3);
            ev   = ($urandom_range(0, 1) == 1);
            epred = ($urandom_range(0, 1) == 1) ? (mBht[tableIndex(ep)] >= 2) : ($urandom_range(0, 1) == 1);
            applyStimulus(($urandom_range(0, 3) == 0), (kind != 0), (kind == 1), (kind == 2),
                          ip, $urandom & 32'hFFFF_FFFC, ev, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                          ep, $urandom & 32'hFFFF_FFFC, epred);
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
